// File: rtl/rx_pkg.sv
// Shared types and default constants for the receive frame controller.
// Defaults assume a 50 MHz board clock and a 40 kHz sample rate.
package rx_pkg;

  localparam int RX_CLK_DIV   = 1250;
  localparam int RX_FRAME_LEN = 80;
  localparam int RX_SYNC_LEN  = 8;
  localparam logic [7:0] RX_SYNC_WORD = 8'hD5;

  typedef enum logic [1:0] {
    IDLE,
    HUNT,
    CAPTURE
  } rx_state_e;

endpackage

// File: rtl/rx_tick_gen.sv
// Enable-gated divider producing the one-cycle sample strobe.
// The counter is held at zero while disabled, so the first strobe lands CLK_DIV cycles after enable.
module rx_tick_gen
  import rx_pkg::*;
#(
  parameter int CLK_DIV = RX_CLK_DIV
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!en_i) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/rx_frame_controller.sv
// Receive sequencer: line synchroniser, sync-word hunt, frame capture
// and a one-deep valid/ready output register with overrun counting.
module rx_frame_controller
  import rx_pkg::*;
#(
  parameter int CLK_DIV   = RX_CLK_DIV,
  parameter int FRAME_LEN = RX_FRAME_LEN,
  parameter int SYNC_LEN  = RX_SYNC_LEN,
  parameter logic [SYNC_LEN-1:0] SYNC_WORD = SYNC_LEN'(RX_SYNC_WORD)
) (
  input  logic                 CLOCK_50,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 rx_in,
  input  logic                 frame_ready,
  output logic                 sample_tick,
  output logic [FRAME_LEN-1:0] frame_data,
  output logic                 frame_valid,
  output logic                 busy,
  output logic [7:0]           overrun_count
);

  localparam int BW = $clog2(FRAME_LEN);
  localparam logic [BW-1:0] LAST_BIT = BW'(FRAME_LEN - 1);

  rx_state_e state_q, state_d;

  logic                 rx_meta_q, rx_s_q;
  logic [SYNC_LEN-1:0]  sync_q, sync_d, sync_shift;
  logic [FRAME_LEN-1:0] fsr_q, fsr_d, fsr_shift;
  logic [BW-1:0]        bcnt_q, bcnt_d;
  logic [FRAME_LEN-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic [7:0]           ovr_q, ovr_d;
  logic                 sync_hit, last_bit, done, tick;

  rx_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .clk_i (CLOCK_50),
    .rst_i (reset),
    .en_i  (enable),
    .tick_o(tick)
  );

  assign sync_shift = {sync_q[SYNC_LEN-2:0], rx_s_q};
  assign fsr_shift  = {fsr_q[FRAME_LEN-2:0], rx_s_q};
  assign sync_hit   = (sync_shift == SYNC_WORD);
  assign last_bit   = (bcnt_q == LAST_BIT);
  assign done       = (state_q == CAPTURE) && tick && last_bit;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (enable) state_d = HUNT;
      end
      HUNT: begin
        if (!enable) state_d = IDLE;
        else if (tick && sync_hit) state_d = CAPTURE;
      end
      CAPTURE: begin
        if (!enable) state_d = IDLE;
        else if (tick && last_bit) state_d = HUNT;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == CAPTURE);
  end

  always_comb begin
    sync_d = sync_q;
    fsr_d  = fsr_q;
    bcnt_d = bcnt_q;
    unique case (state_q)
      IDLE: begin
        sync_d = '0;
      end
      HUNT: begin
        if (tick) begin
          sync_d = sync_hit ? '0 : sync_shift;
          if (sync_hit) bcnt_d = '0;
        end
      end
      CAPTURE: begin
        if (tick) begin
          fsr_d  = fsr_shift;
          bcnt_d = last_bit ? '0 : bcnt_q + 1'b1;
        end
      end
      default: sync_d = '0;
    endcase
  end

  // A completion is accepted only if the register is empty or drains this cycle.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    unique case (1'b1)
      done && (!valid_q || frame_ready): begin
        data_d  = fsr_shift;
        valid_d = 1'b1;
      end
      done && valid_q && !frame_ready: begin
        if (ovr_q != 8'hFF) ovr_d = ovr_q + 8'd1;
      end
      !done && valid_q && frame_ready: begin
        valid_d = 1'b0;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      rx_meta_q <= 1'b0;
      rx_s_q    <= 1'b0;
      sync_q    <= '0;
      fsr_q     <= '0;
      bcnt_q    <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ovr_q     <= '0;
    end else begin
      rx_meta_q <= rx_in;
      rx_s_q    <= rx_meta_q;
      sync_q    <= sync_d;
      fsr_q     <= fsr_d;
      bcnt_q    <= bcnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ovr_q     <= ovr_d;
    end
  end

  assign sample_tick   = tick;
  assign frame_data    = data_q;
  assign frame_valid   = valid_q;
  assign overrun_count = ovr_q;

endmodule

// File: tb/tb_rx_frame_controller.sv
// Directed bench for rx_frame_controller with a fast sample divider.
// Bits are driven MSB first, one per sample tick.
module tb_rx_frame_controller;

  localparam int DIV = 4;

  localparam logic [79:0] P0 = 80'hA5A5_0123_4567_89AB_CDEF;
  localparam logic [79:0] P1 = 80'h1111_2222_3333_4444_5555;
  localparam logic [79:0] P2 = 80'hFEDC_BA98_7654_3210_0F0F;
  localparam logic [79:0] P3 = 80'h0000_FFFF_0000_FFFF_1234;
  localparam logic [79:0] P4 = 80'h8001_8001_8001_8001_8001;
  localparam logic [79:0] P5 = 80'h3C3C_5A5A_9669_C3C3_7E7E;
  localparam logic [79:0] SW = 80'hD5;
  localparam logic [79:0] NM = 80'hD4;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        rx_in;
  logic        frame_ready;
  logic        sample_tick;
  logic [79:0] frame_data;
  logic        frame_valid;
  logic        busy;
  logic [7:0]  overrun_count;

  int   n_checks = 0;
  int   n_fail   = 0;
  logic rdy_hold = 1'b0;
  logic seen_busy;
  logic seen_valid;
  logic [11:0] tmask;
  int   tcount;

  rx_frame_controller #(
    .CLK_DIV(DIV)
  ) dut (
    .CLOCK_50     (clk),
    .reset        (reset),
    .enable       (enable),
    .rx_in        (rx_in),
    .frame_ready  (frame_ready),
    .sample_tick  (sample_tick),
    .frame_data   (frame_data),
    .frame_valid  (frame_valid),
    .busy         (busy),
    .overrun_count(overrun_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [79:0] got,
                       input logic [79:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one bit, wait for the tick edge that samples it.
  task automatic send_bit(input logic b, input logic ack);
    logic got;
    got   = 1'b0;
    rx_in = b;
    for (int i = 0; i < 4 * DIV && !got; i++) begin
      @(negedge clk);
      if (sample_tick) got = 1'b1;
    end
    if (!got) check("tick_wait", 80'(0), 80'(1));
    if (ack) frame_ready = 1'b1;
    @(posedge clk);
    #1;
    frame_ready = rdy_hold;
    seen_busy   = seen_busy | busy;
    seen_valid  = seen_valid | frame_valid;
  endtask

  task automatic send_bits(input logic [79:0] v, input int n,
                           input logic ack_last);
    for (int i = n - 1; i >= 0; i--) begin
      send_bit(v[i], ack_last && (i == 0));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b1;
    enable      = 1'b0;
    rx_in       = 1'b0;
    frame_ready = 1'b0;
    seen_busy   = 1'b0;
    seen_valid  = 1'b0;
    #22;
    check("rst_ctrl",
          80'({sample_tick, busy, frame_valid, overrun_count}), 80'(0));
    check("rst_data", frame_data, 80'(0));
    @(negedge clk);
    reset = 1'b0;

    // Tick timing: strobes on cycles 4, 8, 12 after enable.
    @(posedge clk);
    #1;
    enable = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      tmask[i] = sample_tick;
    end
    check("tick_mask", 80'(tmask), 80'(12'b1000_1000_1000));
    @(posedge clk);
    @(posedge clk);
    #1;
    enable = 1'b0;
    tcount = 0;
    for (int i = 0; i < 3 * DIV; i++) begin
      @(negedge clk);
      if (sample_tick) tcount++;
    end
    check("tick_stop", 80'(tcount), 80'(0));
    check("idle_busy", 80'(busy), 80'(0));

    // Nominal frame with frame_ready held high.
    @(posedge clk);
    #1;
    rdy_hold    = 1'b1;
    frame_ready = 1'b1;
    enable      = 1'b1;
    send_bits(SW, 8, 1'b0);
    check("nom_busy_start", 80'(busy), 80'(1));
    send_bits(P0 >> 1, 79, 1'b0);
    check("nom_busy_79", 80'(busy), 80'(1));
    check("nom_valid_early", 80'(frame_valid), 80'(0));
    send_bit(P0[0], 1'b0);
    check("nom_valid", 80'(frame_valid), 80'(1));
    check("nom_data", frame_data, P0);
    check("nom_busy_end", 80'(busy), 80'(0));
    @(posedge clk);
    #1;
    check("nom_valid_clear", 80'(frame_valid), 80'(0));
    rdy_hold    = 1'b0;
    frame_ready = 1'b0;

    // Near-miss sync word followed by zeros.
    seen_busy  = 1'b0;
    seen_valid = 1'b0;
    send_bits(NM, 8, 1'b0);
    send_bits(80'(0), 80, 1'b0);
    check("nm_busy", 80'(seen_busy), 80'(0));
    check("nm_valid", 80'(seen_valid), 80'(0));

    // Overrun: two frames while the decoder is stalled.
    send_bits(SW, 8, 1'b0);
    send_bits(P1, 80, 1'b0);
    check("ovr_p1_valid", 80'(frame_valid), 80'(1));
    check("ovr_p1_data", frame_data, P1);
    send_bits(SW, 8, 1'b0);
    send_bits(P2, 80, 1'b0);
    check("ovr_count", 80'(overrun_count), 80'(1));
    check("ovr_data_kept", frame_data, P1);
    check("ovr_valid_kept", 80'(frame_valid), 80'(1));
    frame_ready = 1'b1;
    @(posedge clk);
    #1;
    frame_ready = 1'b0;
    check("ovr_drain", 80'(frame_valid), 80'(0));

    // Completion coinciding with frame_ready.
    send_bits(SW, 8, 1'b0);
    send_bits(P3, 80, 1'b0);
    check("coin_p3_data", frame_data, P3);
    send_bits(SW, 8, 1'b0);
    send_bits(P4, 80, 1'b1);
    check("coin_valid", 80'(frame_valid), 80'(1));
    check("coin_data", frame_data, P4);
    check("coin_count", 80'(overrun_count), 80'(1));
    frame_ready = 1'b1;
    @(posedge clk);
    #1;
    frame_ready = 1'b0;
    check("coin_drain", 80'(frame_valid), 80'(0));

    // Enable drop after 40 captured bits, then a clean re-capture.
    send_bits(SW, 8, 1'b0);
    send_bits(P5 >> 40, 40, 1'b0);
    check("en_busy_mid", 80'(busy), 80'(1));
    enable = 1'b0;
    @(posedge clk);
    #1;
    check("en_idle", 80'(busy), 80'(0));
    seen_valid = 1'b0;
    for (int i = 0; i < 5 * DIV; i++) begin
      @(posedge clk);
      #1;
      seen_valid = seen_valid | frame_valid;
    end
    check("en_no_valid", 80'(seen_valid), 80'(0));
    enable = 1'b1;
    send_bits(SW, 8, 1'b0);
    send_bits(P5, 80, 1'b0);
    check("en_valid", 80'(frame_valid), 80'(1));
    check("en_data", frame_data, P5);

    // Asynchronous reset mid-capture.
    send_bits(SW, 8, 1'b0);
    send_bits(P0 >> 60, 20, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check("arst_ctrl",
          80'({sample_tick, busy, frame_valid, overrun_count}), 80'(0));
    check("arst_data", frame_data, 80'(0));
    rx_in = 1'b0;
    @(negedge clk);
    reset      = 1'b0;
    seen_busy  = 1'b0;
    seen_valid = 1'b0;
    for (int i = 0; i < 30 * DIV; i++) begin
      @(posedge clk);
      #1;
      seen_busy  = seen_busy | busy;
      seen_valid = seen_valid | frame_valid;
    end
    check("arst_no_busy", 80'(seen_busy), 80'(0));
    check("arst_no_valid", 80'(seen_valid), 80'(0));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
